// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CPU  = 2'd1,
        R_EXT  = 2'd2
    } rd_owner_e;

    localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of consecutive cycles the external port was denied
module arb_wait_counter #(
    parameter int CNT_W    = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one SRAM port between the CPU MEM stage and the external port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic      w_sat;
    logic      w_cpu_gnt;
    logic      w_ext_gnt;
    logic      w_cpu_rvalid;
    logic      w_ext_rvalid;
    rd_owner_e r_state;

    // CPU has priority unless halted or the external port has waited MAX_WAIT cycles.
    assign w_cpu_gnt = arst_n & enable & cpu_req & ~(ext_req & w_sat);
    assign w_ext_gnt = arst_n & ext_req & ~w_cpu_gnt;

    assign cpu_gnt   = w_cpu_gnt;
    assign ext_gnt   = w_ext_gnt;
    assign cpu_stall = arst_n & enable & cpu_req & ~w_cpu_gnt;

    arb_wait_counter #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .i_clk   (clk),
        .i_rst_n (arst_n),
        .i_clr   (w_ext_gnt | ~ext_req),
        .i_inc   (ext_req & ~w_ext_gnt),
        .o_sat   (w_sat)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_we;
            mem_ren   = ~cpu_we;
        end else if (w_ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_we;
            mem_ren   = ~ext_we;
        end
    end

    // Next owner depends only on this cycle's grant, so the unused encoding falls back to idle.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= R_IDLE;
        end else if (w_cpu_gnt && !cpu_we) begin
            r_state <= R_CPU;
        end else if (w_ext_gnt && !ext_we) begin
            r_state <= R_EXT;
        end else begin
            r_state <= R_IDLE;
        end
    end

    assign w_cpu_rvalid = arst_n & (r_state == R_CPU);
    assign w_ext_rvalid = arst_n & (r_state == R_EXT);
    assign cpu_rvalid   = w_cpu_rvalid;
    assign ext_rvalid   = w_ext_rvalid;
    assign rdata        = (w_cpu_rvalid | w_ext_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic        cpu_req;
    logic        cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic        ext_req;
    logic        ext_we;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [63:0] rdata;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic        mem_ren;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .MAX_WAIT (4),
        .CNT_W    (3)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        arst_n    = 1'b0;
        enable    = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 64'h0;
        cpu_wdata = 64'h0;
        ext_req   = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = 64'h0;
        ext_wdata = 64'h0;
        mem_rdata = 64'h0;
        repeat (3) tick();
        settle();
        check("rst_cpu_gnt",   cpu_gnt,    0);
        check("rst_ext_gnt",   ext_gnt,    0);
        check("rst_mem_ren",   mem_ren,    0);
        check("rst_stall",     cpu_stall,  0);
        check("rst_cpu_rv",    cpu_rvalid, 0);
        check("rst_state",     dut.r_state, 0);
        check("rst_wait_cnt",  dut.u_wait.r_cnt, 0);

        arst_n  = 1'b1;
        cpu_req = 1'b0;
        ext_req = 1'b0;
        tick();

        // 1: single CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
        settle();
        check("t1_cpu_gnt",  cpu_gnt,   1);
        check("t1_mem_ren",  mem_ren,   1);
        check("t1_mem_wen",  mem_wen,   0);
        check("t1_mem_addr", mem_addr,  64'h10);
        check("t1_stall",    cpu_stall, 0);
        tick();
        cpu_req = 1'b0; mem_rdata = 64'hDEAD;
        settle();
        check("t1_cpu_rv",   cpu_rvalid, 1);
        check("t1_ext_rv",   ext_rvalid, 0);
        check("t1_rdata",    rdata,      64'hDEAD);
        tick();
        check("t1_rv_drop",  cpu_rvalid, 0);

        // 2: both requesting every cycle, ext wins every fifth cycle
        cpu_req = 1'b1; cpu_addr = 64'h20;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h30;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("t2_cpu_gnt_%0d", i), cpu_gnt,    (i % 5) != 4);
            check($sformatf("t2_ext_gnt_%0d", i), ext_gnt,    (i % 5) == 4);
            check($sformatf("t2_stall_%0d", i),   cpu_stall,  (i % 5) == 4);
            check($sformatf("t2_addr_%0d", i),    mem_addr,   ((i % 5) == 4) ? 64'h30 : 64'h20);
            check($sformatf("t2_cpu_rv_%0d", i),  cpu_rvalid, (i > 0) && (((i - 1) % 5) != 4));
            check($sformatf("t2_ext_rv_%0d", i),  ext_rvalid, (i > 0) && (((i - 1) % 5) == 4));
            tick();
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        tick();

        // 3: CPU read issued, then enable drops while ext writes
        cpu_req = 1'b1; cpu_addr = 64'h40; mem_rdata = 64'h77;
        settle();
        check("t3_cpu_gnt0", cpu_gnt, 1);
        tick();
        enable = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 64'h8; ext_wdata = 64'h55;
        settle();
        check("t3_ext_gnt",   ext_gnt,   1);
        check("t3_mem_wen",   mem_wen,   1);
        check("t3_mem_ren",   mem_ren,   0);
        check("t3_mem_addr",  mem_addr,  64'h8);
        check("t3_mem_wdata", mem_wdata, 64'h55);
        check("t3_cpu_gnt",   cpu_gnt,   0);
        check("t3_stall",     cpu_stall, 0);
        check("t3_inflight",  cpu_rvalid, 1);
        check("t3_rdata",     rdata,     64'h77);
        tick();
        ext_req = 1'b0; cpu_req = 1'b0;
        settle();
        check("t3_wr_no_rv",  ext_rvalid, 0);
        check("t3_cpu_rv0",   cpu_rvalid, 0);
        enable = 1'b1;
        tick();

        // 4: back-to-back CPU read then ext read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h50;
        settle();
        check("t4_cpu_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h60; mem_rdata = 64'h1111;
        settle();
        check("t4_ext_gnt",  ext_gnt,    1);
        check("t4_cpu_rv1",  cpu_rvalid, 1);
        check("t4_ext_rv1",  ext_rvalid, 0);
        check("t4_rdata1",   rdata,      64'h1111);
        tick();
        ext_req = 1'b0; mem_rdata = 64'h2222;
        settle();
        check("t4_cpu_rv2",  cpu_rvalid, 0);
        check("t4_ext_rv2",  ext_rvalid, 1);
        check("t4_rdata2",   rdata,      64'h2222);
        tick();

        // 5: reset right after a CPU read grant drops the read
        cpu_req = 1'b1; cpu_addr = 64'h70; ext_req = 1'b1;
        settle();
        check("t5_cpu_gnt", cpu_gnt, 1);
        tick();
        arst_n = 1'b0; cpu_req = 1'b0;
        settle();
        check("t5_rv_in_rst", cpu_rvalid, 0);
        check("t5_ext_gnt0",  ext_gnt,    0);
        check("t5_mem_ren0",  mem_ren,    0);
        tick();
        arst_n = 1'b1; ext_req = 1'b0;
        settle();
        check("t5_cpu_rv",   cpu_rvalid, 0);
        check("t5_state",    dut.r_state, 0);
        check("t5_wait_cnt", dut.u_wait.r_cnt, 0);
        tick();

        // 6: ext drops at wait_cnt=3, counter restarts on reassertion
        cpu_req = 1'b1; ext_req = 1'b1;
        repeat (3) begin
            settle();
            check("t6_pre_ext_gnt", ext_gnt, 0);
            tick();
        end
        check("t6_cnt3", dut.u_wait.r_cnt, 3);
        ext_req = 1'b0;
        tick();
        check("t6_cnt_clr", dut.u_wait.r_cnt, 0);
        ext_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t6_cnt_%0d", i),     dut.u_wait.r_cnt, i);
            check($sformatf("t6_ext_gnt_%0d", i), ext_gnt, 0);
            check($sformatf("t6_cpu_gnt_%0d", i), cpu_gnt, 1);
            tick();
        end
        settle();
        check("t6_ext_win",   ext_gnt,   1);
        check("t6_stall_win", cpu_stall, 1);
        tick();
        cpu_req = 1'b0; ext_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
